lzc_scheduler: RTL and testbench

Round-robin scheduler that shares one leading-zero counting engine between `NREQ` requesters. Each requester submits a multi-word operand of `WORD` words, each `WIDTH` bits, most significant word first. The block grants one requester at a time and streams its words through the per-word counter. It accumulates the leading-zero total and returns the result tagged with the requester ID over a valid/ready output handshake.

---
 rtl/lzc_pkg.sv | 24 ++
 rtl/lzc_word.sv | 37 +++
 rtl/lzc_scheduler.sv | 154 +++++++++++++++
 tb/tb_lzc_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
//------------------------------------------------------------------------------
// Module   : lzc_pkg
// Brief    : Shared types and constants for the leading-zero count scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lzc_pkg;

    localparam int LZ_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        RESULT = 2'd2
    } lzc_state_t;

    function automatic bit lzc_width_ok(input int width);
        return (width == 4) || (width == 8) || (width == 16);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lzc_word.sv
//------------------------------------------------------------------------------
// Module   : lzc_word
// Brief    : Combinational leading-zero count of one word, binary-halving tree.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lzc_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        word,
    output logic [$clog2(WIDTH):0]  zeros
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int CW     = LEVELS + 1;

    logic [WIDTH-1:0] w_vec;
    logic [CW-1:0]    w_cnt;

    // Each level tests the upper half of the remaining window; if it is all
    // zero, count it and shift it out. The final MSB test resolves lz(0)=WIDTH.
    always_comb begin
        w_vec = word;
        w_cnt = '0;
        for (int k = 1; k <= LEVELS; k++) begin
            if ((w_vec >> (WIDTH - (WIDTH >> k))) == '0) begin
                w_cnt = w_cnt + CW'(WIDTH >> k);
                w_vec = w_vec << (WIDTH >> k);
            end
        end
        zeros = w_cnt + {{(CW-1){1'b0}}, ~w_vec[WIDTH-1]};
    end

endmodule

`default_nettype wire

// File: rtl/lzc_scheduler.sv
//------------------------------------------------------------------------------
// Module   : lzc_scheduler
// Brief    : Round-robin scheduler sharing one leading-zero engine among
//            NREQ requesters. Define LZC_SCHED_TURBO_EN for early termination.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lzc_scheduler
    import lzc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORD  = 4,
    parameter int NREQ  = 4
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_mode,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           req_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic [LZ_W-1:0]           out_zero
);

    localparam int GW  = $clog2(NREQ);
    localparam int LCW = $clog2(WIDTH) + 1;
    localparam int WCW = $clog2(WORD + 1);

    if (!lzc_width_ok(WIDTH) || (WIDTH * WORD > 511)) begin : g_bad_cfg
        $error("lzc_scheduler: illegal WIDTH/WORD combination");
    end

    lzc_state_t       r_state, w_state_nxt;
    logic [GW-1:0]    r_ptr, r_gid, w_grant;
    logic [LZ_W-1:0]  r_acc;
    logic [WCW-1:0]   r_wcnt;
    logic             r_stop;
    logic             w_any, w_accept, w_nz, w_turbo, w_last;
    logic [WIDTH-1:0] w_word;
    logic [LCW-1:0]   w_lz;

    // First valid requester at or after r_ptr; lowest offset is assigned last.
    always_comb begin : b_arb
        int j;
        j       = 0;
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid[j]) begin
                w_any   = 1'b1;
                w_grant = GW'(j);
            end
        end
    end

    assign w_word   = req_data[int'(r_gid)*WIDTH +: WIDTH];
    assign w_accept = (r_state == FEED) && req_valid[r_gid];
    assign w_nz     = |w_word;

    lzc_word #(.WIDTH(WIDTH)) u_word (
        .word  (w_word),
        .zeros (w_lz)
    );

`ifdef LZC_SCHED_TURBO_EN
    logic r_turbo;

    // Mode is taken live on the first word so a nonzero first word can end it.
    assign w_turbo = (r_wcnt == '0) ? req_mode[r_gid] : r_turbo;

    always_ff @(posedge CLK) begin
        if (rst)
            r_turbo <= 1'b0;
        else if (w_accept && (r_wcnt == '0))
            r_turbo <= req_mode[r_gid];
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = ^req_mode;
    assign w_turbo       = 1'b0;
`endif

    assign w_last = w_accept && ((r_wcnt == WCW'(WORD - 1)) || (w_turbo && w_nz));

    always_ff @(posedge CLK) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)     w_state_nxt = FEED;
            FEED:    if (w_last)    w_state_nxt = RESULT;
            RESULT:  if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        req_done  = '0;
        out_valid = 1'b0;
        out_id    = '0;
        out_zero  = '0;
        if (r_state == FEED) begin
            req_ready[r_gid] = 1'b1;
            req_done[r_gid]  = w_last;
        end
        if (r_state == RESULT) begin
            out_valid = 1'b1;
            out_id    = r_gid;
            out_zero  = r_acc;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_ptr  <= '0;
            r_gid  <= '0;
            r_acc  <= '0;
            r_wcnt <= '0;
            r_stop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_gid  <= w_grant;
                    r_acc  <= '0;
                    r_wcnt <= '0;
                    r_stop <= 1'b0;
                end
                FEED: if (w_accept) begin
                    r_wcnt <= r_wcnt + 1'b1;
                    // Zeros after the first set bit do not belong to the leading run.
                    if (!r_stop) r_acc <= r_acc + {{(LZ_W-LCW){1'b0}}, w_lz};
                    if (w_nz)    r_stop <= 1'b1;
                end
                RESULT: if (out_ready) begin
                    r_ptr <= (r_gid == GW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lzc_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_lzc_scheduler
// Brief    : Self-checking bench for lzc_scheduler with a transaction-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lzc_scheduler;

    localparam int WIDTH = 8;
    localparam int WORD  = 4;
    localparam int NREQ  = 4;
    localparam int GW    = $clog2(NREQ);
    localparam int P_IDLE = 0, P_FEED = 1, P_RESULT = 2;
`ifdef LZC_SCHED_TURBO_EN
    localparam bit TURBO = 1'b1;
`else
    localparam bit TURBO = 1'b0;
`endif

    typedef struct packed {
        logic                  mode;
        logic [WORD*WIDTH-1:0] data;
    } op_t;

    logic                  CLK = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_mode, req_ready, req_done;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  out_valid, out_ready;
    logic [GW-1:0]         out_id;
    logic [8:0]            out_zero;

    lzc_scheduler #(.WIDTH(WIDTH), .WORD(WORD), .NREQ(NREQ)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_done  (req_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_zero  (out_zero)
    );

    always #5 CLK = ~CLK;

    int  n_cmp, n_fail;
    op_t pend [NREQ][$];
    int  wptr [NREQ];
    int  m_phase, m_gid, m_ptr, m_cnt, m_len, m_zero, m_rcyc;
    bit  m_fresh;
    int  obs_acc, obs_done_at;
    int  log_id[$], log_zero[$], log_nw[$], log_done[$];
    int  gap_mode, gap_word, hold_n, rst_at;
    bit  gap_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word_of(input op_t op, input int k);
        logic [WORD*WIDTH-1:0] d;
        d = op.data;
        return d[(WORD-1-k)*WIDTH +: WIDTH];
    endfunction

    // Leading zeros of the whole concatenated operand, MSB first.
    function automatic int calc_lz(input op_t op);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int b = WORD*WIDTH-1; b >= 0; b--) begin
            if (op.data[b]) seen = 1'b1;
            if (!seen) n++;
        end
        return n;
    endfunction

    function automatic int calc_len(input op_t op);
        if (!(TURBO && op.mode)) return WORD;
        for (int k = 0; k < WORD; k++)
            if (word_of(op, k) != '0) return k + 1;
        return WORD;
    endfunction

    function automatic op_t mk_op(input logic m, input logic [7:0] a, b, c, d);
        op_t op;
        op.mode = m;
        op.data = {a, b, c, d};
        return op;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        case ($urandom_range(0, 3))
            0, 1:    return '0;
            2:       return WIDTH'($urandom_range(1, 255));
            default: return WIDTH'(8'h01 << $urandom_range(0, 7));
        endcase
    endfunction

    function automatic bit busy();
        bit b;
        b = (m_phase != P_IDLE);
        for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic clear_log();
        log_id.delete();
        log_zero.delete();
        log_nw.delete();
        log_done.delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_req_done",  req_done,  0);
        chk("rst_out_id",    out_id,    0);
        chk("rst_out_zero",  out_zero,  0);
        m_phase = P_IDLE;
        m_ptr   = 0;
        m_fresh = 1'b1;
        for (int i = 0; i < NREQ; i++) wptr[i] = 0;
    endtask

    // Drives every requester from its pending queue and compares each cycle
    // against the transaction model.
    task automatic run(input int max_cyc);
        int              cyc;
        logic [NREQ-1:0] v;
        bit              r, acc;
        op_t             op;
        cyc = 0;
        while (busy() && cyc < max_cyc) begin
            @(negedge CLK);
            cyc++;
            v = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i].size() > 0) begin
                    op = pend[i][0];
                    v[i] = 1'b1;
                    if (gap_mode == 1 && $urandom_range(0, 3) == 0) v[i] = 1'b0;
                    if (gap_mode == 2 && !gap_done && m_phase == P_FEED && i == m_gid
                        && m_cnt == gap_word) begin
                        v[i] = 1'b0;
                        gap_done = 1'b1;
                    end
                    req_data[i*WIDTH +: WIDTH] = word_of(op, wptr[i]);
                    req_mode[i] = op.mode;
                end
            end
            req_valid = v;
            r = (rst_at >= 0) && (m_phase == P_FEED) && (m_cnt == rst_at);
            if (r) rst_at = -1;
            rst = r;
            if (m_phase == P_RESULT)
                out_ready = (hold_n < 0) ? 1'($urandom_range(0, 1)) : (m_rcyc >= hold_n);
            else
                out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = (m_phase == P_FEED) && v[m_gid];
            chk("req_ready", req_ready, (m_phase == P_FEED) ? (1 << m_gid) : 0);
            chk("req_done", req_done, (acc && (m_cnt + 1 == m_len)) ? (1 << m_gid) : 0);
            chk("out_valid", out_valid, m_phase == P_RESULT);
            if (m_phase == P_RESULT) begin
                chk("out_id", out_id, m_gid);
                chk("out_zero", out_zero, m_zero);
            end
            if (m_fresh) begin
                chk("post_rst_out_id", out_id, 0);
                chk("post_rst_out_zero", out_zero, 0);
                m_fresh = 1'b0;
            end
            if (|(v & req_ready)) obs_acc++;
            if (|req_done) obs_done_at = obs_acc;

            if (r) begin
                m_phase = P_IDLE;
                m_ptr   = 0;
                m_fresh = 1'b1;
                for (int i = 0; i < NREQ; i++) wptr[i] = 0;
            end else begin
                case (m_phase)
                    P_IDLE: begin
                        for (int k = 0; k < NREQ; k++) begin
                            if (m_phase == P_IDLE && v[(m_ptr + k) % NREQ]) begin
                                m_gid   = (m_ptr + k) % NREQ;
                                m_phase = P_FEED;
                                m_cnt   = 0;
                                m_len   = calc_len(pend[m_gid][0]);
                                m_zero  = calc_lz(pend[m_gid][0]);
                                obs_acc = 0;
                                obs_done_at = 0;
                            end
                        end
                    end
                    P_FEED: if (v[m_gid]) begin
                        m_cnt++;
                        wptr[m_gid]++;
                        if (m_cnt == m_len) begin
                            pend[m_gid].delete(0);
                            wptr[m_gid] = 0;
                            m_phase = P_RESULT;
                            m_rcyc  = 0;
                        end
                    end
                    default: if (out_ready) begin
                        log_id.push_back(int'(out_id));
                        log_zero.push_back(int'(out_zero));
                        log_nw.push_back(obs_acc);
                        log_done.push_back(obs_done_at);
                        m_ptr   = (m_gid + 1) % NREQ;
                        m_phase = P_IDLE;
                    end else begin
                        m_rcyc++;
                    end
                endcase
            end
        end
        chk("drain", busy(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = '0;
        req_mode = '0;
        req_data = '0;
        out_ready = 1'b0;
        m_phase = P_IDLE;
        m_gid = 0;
        m_cnt = 0;
        m_len = WORD;
        m_zero = 0;
        m_rcyc = 0;
        gap_mode = 0;
        gap_word = 0;
        hold_n = 0;
        rst_at = -1;
        gap_done = 1'b0;
        do_reset();

        // Normal four-word operand on requester 0.
        clear_log();
        pend[0].push_back(mk_op(1'b0, 8'h00, 8'h00, 8'h1F, 8'h80));
        run(100);
        chk("s1_count", log_zero.size(), 1);
        chk("s1_zero", log_zero[0], 19);
        chk("s1_id", log_id[0], 0);
        chk("s1_words", log_nw[0], 4);
        chk("s1_done_word", log_done[0], 4);

        // All-zero operand on requester 1.
        clear_log();
        pend[1].push_back(mk_op(1'b0, 8'h00, 8'h00, 8'h00, 8'h00));
        run(100);
        chk("s2_zero", log_zero[0], 32);
        chk("s2_id", log_id[0], 1);

        // Turbo request on requester 2.
        clear_log();
        pend[2].push_back(mk_op(1'b1, 8'h00, 8'h40, 8'hFF, 8'hFF));
        run(100);
        chk("s3_zero", log_zero[0], 9);
        chk("s3_words", log_nw[0], TURBO ? 2 : 4);
        chk("s3_done_word", log_done[0], TURBO ? 2 : 4);

        // Two requesters contending from reset alternate.
        do_reset();
        clear_log();
        for (int n = 0; n < 2; n++) begin
            pend[0].push_back(mk_op(1'b0, rnd_word(), rnd_word(), rnd_word(), rnd_word()));
            pend[2].push_back(mk_op(1'b0, rnd_word(), rnd_word(), rnd_word(), rnd_word()));
        end
        run(200);
        chk("s4_count", log_id.size(), 4);
        chk("s4_grant0", log_id[0], 0);
        chk("s4_grant1", log_id[1], 2);
        chk("s4_grant2", log_id[2], 0);
        chk("s4_grant3", log_id[3], 2);

        // Mid-feed gap and a 3-cycle result backpressure with a waiter queued.
        clear_log();
        gap_mode = 2;
        gap_word = 1;
        gap_done = 1'b0;
        hold_n = 3;
        pend[3].push_back(mk_op(1'b0, 8'h00, 8'h05, 8'h00, 8'hFF));
        pend[1].push_back(mk_op(1'b0, 8'h00, 8'h00, 8'h00, 8'h21));
        run(200);
        chk("s5_first_id", log_id[0], 3);
        chk("s5_second_id", log_id[1], 1);
        chk("s5_zero", log_zero[0], 13);
        chk("s5_words", log_nw[0], 4);
        chk("s5_done_word", log_done[0], 4);

        // Reset after two words; pointer returns to 0 so requester 1 goes first.
        clear_log();
        gap_mode = 0;
        hold_n = 0;
        rst_at = 2;
        pend[3].push_back(mk_op(1'b0, 8'h00, 8'h00, 8'h00, 8'h03));
        pend[1].push_back(mk_op(1'b0, 8'h0F, 8'h00, 8'h00, 8'h00));
        run(200);
        chk("s6_count", log_id.size(), 2);
        chk("s6_first_id", log_id[0], 1);
        chk("s6_zero1", log_zero[0], 4);
        chk("s6_second_id", log_id[1], 3);
        chk("s6_zero3", log_zero[1], 30);

        // Randomized traffic: gaps, backpressure and mixed modes.
        clear_log();
        gap_mode = 1;
        hold_n = -1;
        for (int n = 0; n < 24; n++)
            pend[$urandom_range(0, NREQ-1)].push_back(
                mk_op(1'($urandom_range(0, 1)), rnd_word(), rnd_word(), rnd_word(), rnd_word()));
        run(4000);
        chk("s7_count", log_id.size(), 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
